crypto_seq_ctrl: RTL and testbench

- Sequencer for the affine-conversion tail of the X25519 datapath: result = Rx * Rz^-1 mod p.
- Accepts a projective (Rx, Rz) pair from montgomery_ladder and drives three shared units in order: mod_inverse, multiplier_256, serial_modulo.
- Returns the 255-bit affine x-coordinate to crypto_top.
- Adds a per-stage watchdog and an Rz==0 bypass.

---
 rtl/crypto_pkg.sv | 31 +++
 rtl/stage_watchdog.sv | 30 +++
 rtl/crypto_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_crypto_seq_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared widths, state encoding and watchdog defaults for the X25519 controllers.
package crypto_pkg;

  localparam int FE_W     = 255;
  localparam int MUL_IN_W = 256;
  localparam int PROD_W   = 512;

  localparam int TIMEOUT_DEFAULT = 65535;
  localparam int TMR_W_DEFAULT   = 17;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INV_GO   = 3'd1;
  localparam logic [2:0] ST_INV_WAIT = 3'd2;
  localparam logic [2:0] ST_MUL_GO   = 3'd3;
  localparam logic [2:0] ST_MUL_WAIT = 3'd4;
  localparam logic [2:0] ST_MOD_GO   = 3'd5;
  localparam logic [2:0] ST_MOD_WAIT = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_INV_GO   = ST_INV_GO,
    S_INV_WAIT = ST_INV_WAIT,
    S_MUL_GO   = ST_MUL_GO,
    S_MUL_WAIT = ST_MUL_WAIT,
    S_MOD_GO   = ST_MOD_GO,
    S_MOD_WAIT = ST_MOD_WAIT,
    S_DONE     = ST_DONE
  } seq_state_e;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle watchdog: cleared at stage start, counts while enabled,
// saturates at TIMEOUT_CYCLES-1 and flags expiry there.
module stage_watchdog
  import crypto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int TMR_W          = TMR_W_DEFAULT
) (
  input  logic crypto_clk,
  input  logic crypto_reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count;

  assign expire = (count == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge crypto_clk or posedge crypto_reset) begin
    if (crypto_reset)           count <= '0;
    else if (clear)             count <= '0;
    else if (enable && !expire) count <= count + TMR_W'(1);
  end

endmodule

// File: rtl/crypto_seq_ctrl.sv
// Affine-conversion sequencer: result = Rx * Rz^-1 mod p, driving mod_inverse,
// multiplier_256 and serial_modulo in turn, with per-stage watchdog and Rz==0 bypass.
module crypto_seq_ctrl
  import crypto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int TMR_W          = TMR_W_DEFAULT
) (
  input  logic                crypto_clk,
  input  logic                crypto_reset,
  input  logic                ctrl_valid,
  output logic                ctrl_ready,
  input  logic [FE_W-1:0]     ctrl_Rx,
  input  logic [FE_W-1:0]     ctrl_Rz,
  output logic                inv_valid,
  output logic [FE_W-1:0]     inv_in,
  input  logic [FE_W-1:0]     inv_inverse,
  input  logic                inv_data_valid,
  output logic                mul_start,
  output logic [MUL_IN_W-1:0] mul_in1,
  output logic [MUL_IN_W-1:0] mul_in2,
  input  logic [PROD_W-1:0]   mul_out,
  input  logic                mul_done,
  output logic                mod_start,
  output logic [PROD_W-1:0]   mod_A,
  input  logic [FE_W-1:0]     mod_result,
  input  logic                mod_done,
  output logic [FE_W-1:0]     ctrl_data_out,
  output logic                ctrl_data_valid,
  output logic                ctrl_error
);

  seq_state_e        state, state_d;
  logic [FE_W-1:0]   rx_q, rz_q, inv_q;
  logic [PROD_W-1:0] prod_q;
  logic accept, bypass, wd_clear, wd_enable, wd_expire;
  logic ld_inv, ld_prod, ld_res, abort, set_valid;

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_watchdog (
    .crypto_clk  (crypto_clk),
    .crypto_reset(crypto_reset),
    .clear       (wd_clear),
    .enable      (wd_enable),
    .expire      (wd_expire)
  );

  always_ff @(posedge crypto_clk or posedge crypto_reset) begin
    if (crypto_reset) state <= S_IDLE;
    else              state <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    ctrl_ready = 1'b0;
    inv_valid  = 1'b0;
    mul_start  = 1'b0;
    mod_start  = 1'b0;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    accept     = 1'b0;
    bypass     = 1'b0;
    ld_inv     = 1'b0;
    ld_prod    = 1'b0;
    ld_res     = 1'b0;
    abort      = 1'b0;
    set_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        ctrl_ready = 1'b1;
        if (ctrl_valid) begin
          accept  = 1'b1;
          bypass  = (ctrl_Rz == '0);
          state_d = bypass ? S_DONE : S_INV_GO;
        end
      end
      S_INV_GO: begin
        inv_valid = 1'b1;
        wd_clear  = 1'b1;
        state_d   = S_INV_WAIT;
      end
      // Done has priority over expiry in every wait state.
      S_INV_WAIT: begin
        wd_enable = 1'b1;
        if (inv_data_valid) begin
          ld_inv  = 1'b1;
          state_d = S_MUL_GO;
        end else if (wd_expire) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_MUL_GO: begin
        mul_start = 1'b1;
        wd_clear  = 1'b1;
        state_d   = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        wd_enable = 1'b1;
        if (mul_done) begin
          ld_prod = 1'b1;
          state_d = S_MOD_GO;
        end else if (wd_expire) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_MOD_GO: begin
        mod_start = 1'b1;
        wd_clear  = 1'b1;
        state_d   = S_MOD_WAIT;
      end
      S_MOD_WAIT: begin
        wd_enable = 1'b1;
        if (mod_done) begin
          ld_res  = 1'b1;
          state_d = S_DONE;
        end else if (wd_expire) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        set_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge crypto_clk or posedge crypto_reset) begin
    if (crypto_reset) begin
      rx_q            <= '0;
      rz_q            <= '0;
      inv_q           <= '0;
      prod_q          <= '0;
      ctrl_data_out   <= '0;
      ctrl_data_valid <= 1'b0;
      ctrl_error      <= 1'b0;
    end else begin
      if (accept) begin
        rx_q            <= ctrl_Rx;
        rz_q            <= ctrl_Rz;
        ctrl_data_valid <= 1'b0;
        ctrl_error      <= 1'b0;
        if (bypass) ctrl_data_out <= '0;
      end
      if (ld_inv)  inv_q         <= inv_inverse;
      if (ld_prod) prod_q        <= mul_out;
      if (ld_res)  ctrl_data_out <= mod_result;
      if (abort) begin
        ctrl_error    <= 1'b1;
        ctrl_data_out <= '0;
      end
      if (set_valid) ctrl_data_valid <= 1'b1;
    end
  end

  assign inv_in  = rz_q;
  assign mul_in1 = {1'b0, rx_q};
  assign mul_in2 = {1'b0, inv_q};
  assign mod_A   = prod_q;

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Directed bench for crypto_seq_ctrl; the bench plays the three arithmetic
// units with fixed, hand-chosen latencies and response values.
module tb_crypto_seq_ctrl;

  logic         crypto_clk;
  logic         crypto_reset;
  logic         ctrl_valid;
  logic         ctrl_ready;
  logic [254:0] ctrl_Rx, ctrl_Rz;
  logic         inv_valid;
  logic [254:0] inv_in, inv_inverse;
  logic         inv_data_valid;
  logic         mul_start;
  logic [255:0] mul_in1, mul_in2;
  logic [511:0] mul_out;
  logic         mul_done;
  logic         mod_start;
  logic [511:0] mod_A;
  logic [254:0] mod_result;
  logic         mod_done;
  logic [254:0] ctrl_data_out;
  logic         ctrl_data_valid;
  logic         ctrl_error;

  int total = 0;
  int bad   = 0;
  int n_inv = 0;
  int n_mul = 0;
  int n_mod = 0;

  crypto_seq_ctrl #(.TIMEOUT_CYCLES(16), .TMR_W(5)) dut (
    .crypto_clk     (crypto_clk),
    .crypto_reset   (crypto_reset),
    .ctrl_valid     (ctrl_valid),
    .ctrl_ready     (ctrl_ready),
    .ctrl_Rx        (ctrl_Rx),
    .ctrl_Rz        (ctrl_Rz),
    .inv_valid      (inv_valid),
    .inv_in         (inv_in),
    .inv_inverse    (inv_inverse),
    .inv_data_valid (inv_data_valid),
    .mul_start      (mul_start),
    .mul_in1        (mul_in1),
    .mul_in2        (mul_in2),
    .mul_out        (mul_out),
    .mul_done       (mul_done),
    .mod_start      (mod_start),
    .mod_A          (mod_A),
    .mod_result     (mod_result),
    .mod_done       (mod_done),
    .ctrl_data_out  (ctrl_data_out),
    .ctrl_data_valid(ctrl_data_valid),
    .ctrl_error     (ctrl_error)
  );

  initial crypto_clk = 1'b0;
  always #5 crypto_clk = ~crypto_clk;

  // Start pulses seen at each active edge.
  always @(posedge crypto_clk) begin
    if (inv_valid) n_inv <= n_inv + 1;
    if (mul_start) n_mul <= n_mul + 1;
    if (mod_start) n_mod <= n_mod + 1;
  end

  task automatic tick();
    @(posedge crypto_clk);
    #1;
  endtask

  // One full request with unit latencies li/lm/lr (wait cycles up to and
  // including the done cycle). With stray set, a second ctrl_valid is held
  // during MUL_WAIT and inv_data_valid is held during MOD_WAIT.
  task automatic run_req(input string tag, input logic [254:0] rx, input logic [254:0] rz,
                         input logic [254:0] inv_r, input logic [511:0] prod,
                         input logic [254:0] res, input int li, input int lm, input int lr,
                         input bit stray);
    int c_inv, c_mul, c_mod;
    c_inv = n_inv; c_mul = n_mul; c_mod = n_mod;
    ctrl_valid = 1'b1; ctrl_Rx = rx; ctrl_Rz = rz;
    total++;
    if (ctrl_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_before_accept: got %b want 1", tag, ctrl_ready);
    end
    tick();
    ctrl_valid = 1'b0;
    // INV_GO: start pulse, busy, valid and error cleared by the accept
    total++;
    if ({inv_valid, ctrl_ready, ctrl_data_valid, ctrl_error} !== 4'b1000) begin
      bad++; $display("FAIL %s inv_go_flags: got %b want 1000", tag,
                      {inv_valid, ctrl_ready, ctrl_data_valid, ctrl_error});
    end
    total++;
    if (inv_in !== rz) begin
      bad++; $display("FAIL %s inv_in: got %h want %h", tag, inv_in, rz);
    end
    tick();
    for (int k = 1; k <= li; k++) begin
      inv_data_valid = (k == li);
      inv_inverse    = (k == li) ? inv_r : '0;
      tick();
    end
    inv_data_valid = 1'b0;
    total++;
    if (mul_start !== 1'b1) begin
      bad++; $display("FAIL %s mul_go: got %b want 1", tag, mul_start);
    end
    total++;
    if ({mul_in1, mul_in2} !== {1'b0, rx, 1'b0, inv_r}) begin
      bad++; $display("FAIL %s mul_operands: got %h %h want %h %h", tag, mul_in1, mul_in2,
                      {1'b0, rx}, {1'b0, inv_r});
    end
    tick();
    for (int k = 1; k <= lm; k++) begin
      mul_done = (k == lm);
      mul_out  = (k == lm) ? prod : '0;
      if (stray) begin
        ctrl_valid = (k < lm); ctrl_Rx = ~rx; ctrl_Rz = '0;
      end
      tick();
    end
    mul_done = 1'b0; ctrl_valid = 1'b0;
    total++;
    if ({mod_start, mod_A} !== {1'b1, prod}) begin
      bad++; $display("FAIL %s mod_go: got %b %h want 1 %h", tag, mod_start, mod_A, prod);
    end
    tick();
    for (int k = 1; k <= lr; k++) begin
      mod_done   = (k == lr);
      mod_result = (k == lr) ? res : '0;
      if (stray) begin
        inv_data_valid = 1'b1; inv_inverse = ~inv_r;
      end
      tick();
    end
    mod_done = 1'b0; inv_data_valid = 1'b0;
    // DONE: result loaded, valid not yet raised
    total++;
    if ({ctrl_data_valid, ctrl_ready, ctrl_error} !== 3'b000) begin
      bad++; $display("FAIL %s done_flags: got %b want 000", tag,
                      {ctrl_data_valid, ctrl_ready, ctrl_error});
    end
    total++;
    if (ctrl_data_out !== res) begin
      bad++; $display("FAIL %s done_data: got %h want %h", tag, ctrl_data_out, res);
    end
    tick();
    total++;
    if ({ctrl_data_valid, ctrl_ready, ctrl_error} !== 3'b110) begin
      bad++; $display("FAIL %s idle_flags: got %b want 110", tag,
                      {ctrl_data_valid, ctrl_ready, ctrl_error});
    end
    total++;
    if (ctrl_data_out !== res) begin
      bad++; $display("FAIL %s result: got %h want %h", tag, ctrl_data_out, res);
    end
    total++;
    if ({n_inv - c_inv, n_mul - c_mul, n_mod - c_mod} !== {32'd1, 32'd1, 32'd1}) begin
      bad++; $display("FAIL %s pulse_counts: got %0d %0d %0d want 1 1 1", tag,
                      n_inv - c_inv, n_mul - c_mul, n_mod - c_mod);
    end
    total++;
    if ({inv_in, mul_in1, mul_in2, mod_A} !== {rz, 1'b0, rx, 1'b0, inv_r, prod}) begin
      bad++; $display("FAIL %s operands_held: got %h %h %h want %h %h %h", tag,
                      inv_in, mul_in2, mod_A, rz, {1'b0, inv_r}, prod);
    end
  endtask

  task automatic test_reset();
    crypto_reset = 1'b1;
    ctrl_valid = 1'b0; ctrl_Rx = '0; ctrl_Rz = '0;
    inv_inverse = '0; inv_data_valid = 1'b0;
    mul_out = '0; mul_done = 1'b0;
    mod_result = '0; mod_done = 1'b0;
    tick(); tick();
    total++;
    if ({ctrl_ready, ctrl_data_valid, ctrl_error, inv_valid, mul_start, mod_start} !== 6'b100000) begin
      bad++; $display("FAIL reset_flags: got %b want 100000",
                      {ctrl_ready, ctrl_data_valid, ctrl_error, inv_valid, mul_start, mod_start});
    end
    total++;
    if ({ctrl_data_out, inv_in, mul_in1, mul_in2, mod_A} !== '0) begin
      bad++; $display("FAIL reset_data: got %h %h %h want 0", ctrl_data_out, inv_in, mod_A);
    end
    crypto_reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    run_req("nominal", 255'd9, 255'd1, 255'd1, 512'd9, 255'd9, 1, 1, 1, 1'b0);
  endtask

  // Wide operands with bit 254 set check the fixed zero-extension; unit
  // responses are arbitrary tags since this block does no arithmetic on them.
  task automatic test_wide();
    logic [254:0] rx, rz, inv_r, res;
    logic [511:0] prod;
    rx = '0; rx[254] = 1'b1; rx[0] = 1'b1;
    rz = 255'h1234_5678;
    inv_r = '0; inv_r[254] = 1'b1; inv_r[7:0] = 8'h5a;
    prod = '0; prod[511] = 1'b1; prod[31:0] = 32'hdead_beef;
    res = '0; res[254] = 1'b1; res[15:0] = 16'hc0de;
    run_req("wide", rx, rz, inv_r, prod, res, 2, 1, 3, 1'b0);
  endtask

  task automatic test_bypass();
    int c_inv, c_mul, c_mod;
    c_inv = n_inv; c_mul = n_mul; c_mod = n_mod;
    ctrl_valid = 1'b1; ctrl_Rx = 255'h1234; ctrl_Rz = '0;
    tick();
    ctrl_valid = 1'b0;
    total++;
    if ({ctrl_ready, ctrl_data_valid, ctrl_error} !== 3'b000) begin
      bad++; $display("FAIL bypass_busy: got %b want 000", {ctrl_ready, ctrl_data_valid, ctrl_error});
    end
    total++;
    if (ctrl_data_out !== '0) begin
      bad++; $display("FAIL bypass_cleared: got %h want 0", ctrl_data_out);
    end
    tick();
    total++;
    if ({ctrl_data_valid, ctrl_ready, ctrl_error, ctrl_data_out} !== {3'b110, 255'd0}) begin
      bad++; $display("FAIL bypass_result: got %b %h want 110 0",
                      {ctrl_data_valid, ctrl_ready, ctrl_error}, ctrl_data_out);
    end
    total++;
    if ((n_inv - c_inv) + (n_mul - c_mul) + (n_mod - c_mod) !== 0) begin
      bad++; $display("FAIL bypass_pulses: got %0d want 0",
                      (n_inv - c_inv) + (n_mul - c_mul) + (n_mod - c_mod));
    end
  endtask

  // mul_done never comes: 16 MUL_WAIT cycles busy, then abort to IDLE.
  task automatic test_timeout();
    int c_mod;
    bit early;
    c_mod = n_mod;
    early = 1'b0;
    ctrl_valid = 1'b1; ctrl_Rx = 255'd77; ctrl_Rz = 255'd3;
    tick();
    ctrl_valid = 1'b0;
    tick();
    inv_data_valid = 1'b1; inv_inverse = 255'd5;
    tick();
    inv_data_valid = 1'b0;
    total++;
    if (mul_start !== 1'b1) begin
      bad++; $display("FAIL timeout_mul_go: got %b want 1", mul_start);
    end
    tick();
    for (int k = 1; k <= 16; k++) begin
      if (ctrl_ready || ctrl_error || ctrl_data_valid) early = 1'b1;
      tick();
    end
    total++;
    if (early !== 1'b0) begin
      bad++; $display("FAIL timeout_early: got %b want 0", early);
    end
    total++;
    if ({ctrl_error, ctrl_ready, ctrl_data_valid} !== 3'b110) begin
      bad++; $display("FAIL timeout_flags: got %b want 110", {ctrl_error, ctrl_ready, ctrl_data_valid});
    end
    total++;
    if (ctrl_data_out !== '0) begin
      bad++; $display("FAIL timeout_data: got %h want 0", ctrl_data_out);
    end
    total++;
    if (n_mod - c_mod !== 0) begin
      bad++; $display("FAIL timeout_no_mod: got %0d want 0", n_mod - c_mod);
    end
  endtask

  // mod_done lands on the 16th MOD_WAIT cycle, the same cycle the watchdog expires.
  task automatic test_collision();
    run_req("collision", 255'd21, 255'd4, 255'd6, 512'd126, 255'd33, 1, 1, 16, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    ctrl_valid = 1'b1; ctrl_Rx = 255'd100; ctrl_Rz = 255'd200;
    tick();
    ctrl_valid = 1'b0;
    tick(); tick();
    total++;
    if ({ctrl_ready, ctrl_data_out} !== {1'b0, 255'd33}) begin
      bad++; $display("FAIL midrun_before: got %b %h want 0 21", ctrl_ready, ctrl_data_out);
    end
    #3 crypto_reset = 1'b1;
    #1;
    total++;
    if ({ctrl_ready, ctrl_data_valid, ctrl_error, inv_valid, mul_start, mod_start} !== 6'b100000) begin
      bad++; $display("FAIL midrun_reset_flags: got %b want 100000",
                      {ctrl_ready, ctrl_data_valid, ctrl_error, inv_valid, mul_start, mod_start});
    end
    total++;
    if ({ctrl_data_out, inv_in, mul_in1, mul_in2, mod_A} !== '0) begin
      bad++; $display("FAIL midrun_reset_data: got %h %h %h want 0", ctrl_data_out, inv_in, mod_A);
    end
    tick();
    crypto_reset = 1'b0;
    tick();
    run_req("after_reset", 255'd15, 255'd2, 255'd8, 512'd120, 255'd44, 1, 2, 1, 1'b0);
  endtask

  task automatic test_busy_stray();
    run_req("stray", 255'd50, 255'd10, 255'd12, 512'd600, 255'd55, 1, 3, 3, 1'b1);
    run_req("after_stray", 255'd3, 255'd3, 255'd1, 512'd3, 255'd3, 1, 1, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bypass();
    test_wide();
    test_timeout();
    test_collision();
    test_reset_mid_run();
    test_busy_stray();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
